fwd_hazard_tracker: RTL and testbench
=====================================

Name: fwd_hazard_tracker

Overview:
- Parametrised forwarding and hazard unit for the RV32I pipeline.
- Keeps its own shift-register scoreboard of in-flight destination writes, FWD_DEPTH stages deep, instead of taking per-stage write-address and write-enable inputs.
- For each of NUM_SRC source operands, produces an encoded forwarding-mux select and a load-use stall request.
- Sits beside decode/execute and drives the ALU-input bypass muxes and the IF/ID stall logic.

Parameters:
- NUM_SRC, 2, number of source operands looked up per cycle (rs1, rs2, ...).
- FWD_DEPTH, 2, number of tracked stages after decode (1 = EX, 2 = MA, 3 = WB, ...); legal range 1..6.
- ADDR_W, 5, register address width.
- LOAD_STAGE, 2, first tracker index whose load result is forwardable; must satisfy 1 <= LOAD_STAGE <= FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1), derived, not overridden; width of each select field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  pipeline moves this cycle; 0 = global freeze, all state held.
- flush  in  1  squash the instruction leaving decode this cycle (branch taken).
- id_valid  in  1  decode slot holds a real instruction.
- id_regwrite  in  1  decode instruction writes rd.
- id_is_load  in  1  decode instruction is a load.
- id_rd  in  ADDR_W  decode destination register.
- src_addr  in  NUM_SRC*ADDR_W  source addresses; field i at bits [i*ADDR_W +: ADDR_W].
- fwd_sel  out  NUM_SRC*SEL_W  per-source select; 0 = register file, k = result from tracker entry k.
- stall  out  1  load-use hazard; hold IF/ID and insert a bubble.
- busy  out  1  any tracker entry valid.

Behaviour:
- Tracker entries e[1..FWD_DEPTH], each holding {v, rd, ld}.
- Reset (asynchronous, rst_n=0): all v=0, rd=0, ld=0. Consequently fwd_sel=0, stall=0, busy=0. Reset mid-operation drops every in-flight entry immediately.
- Shift on a rising clk edge when advance=1:
  - e[k] <= e[k-1] for k >= 2.
  - e[1] <= {id_valid & id_regwrite & (id_rd != 0) & ~stall & ~flush, id_rd, id_is_load}.
  - The oldest entry is discarded.
- advance=0: all entries hold, regardless of flush or stall.
- Simultaneous stall and flush: flush wins. The bubble is inserted and e[1] is invalid either way.
- Lookup for each source i (combinational from registered state and src_addr):
  - match_k = e[k].v & (e[k].rd == src_i) & (src_i != 0).
  - m is the smallest matching k (youngest result wins).
  - No match: fwd_sel_i = 0.
- Load-use hazard:
  - If e[m].ld = 1 and m < LOAD_STAGE: hazard_i = 1 and fwd_sel_i is forced to 0.
  - Older, non-youngest matches are never used in this case.
  - Otherwise fwd_sel_i = m.
- stall = OR of hazard_i over all sources. It is combinational, with no registered latency.
- Default load-use timing (LOAD_STAGE=2):
  - A load immediately followed by a dependent instruction stalls exactly 1 cycle.
  - After the stall cycle the load sits in e[2] and the dependent instruction gets fwd_sel = 2.
- Latency: forwarding is visible the cycle after the producer leaves decode with advance=1.
- A result stops being forwardable once it shifts past e[FWD_DEPTH]. Beyond that the register file supplies it, and the writeback/regfile write-before-read path guarantees correctness.
- Source address 0 always yields fwd_sel=0 and never stalls.
- busy = OR of all e[k].v.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fwd_cnt  out  32: counts cycles with advance=1 and ~stall in which any fwd_sel_i != 0.
  - perf_stall_cnt  out  32: counts cycles with advance=1 and stall=1.
  - Both counters clear on rst_n=0 and wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and counters are absent and the core behaviour is identical.

Test Plan:
- Back-to-back dependency, default params: ADD x5 issued, then src_addr[0]=5 next cycle -> fwd_sel[0]=1, stall=0. One cycle later with no new write to x5 -> fwd_sel[0]=2. One further cycle -> fwd_sel[0]=0.
- Youngest wins: writes to x7 issued in two consecutive cycles, then src_addr[1]=7 -> fwd_sel[1]=1, not 2.
- Load-use: LW x3 issued, next cycle src_addr[0]=3 -> stall=1, fwd_sel[0]=0, e[1] bubbled. Following cycle -> stall=0, fwd_sel[0]=2.
- x0 and flush:
  - Instruction writing x0, then src=0 -> fwd_sel=0.
  - Write to x9 issued with flush=1, then src=9 -> fwd_sel=0.
- Freeze: producer in e[1] with advance=0 held for 3 cycles -> fwd_sel stays 1 throughout. Asserting rst_n=0 mid-freeze -> fwd_sel=0 and busy=0 immediately, without waiting for a clock edge.
- Parametric: FWD_DEPTH=4, LOAD_STAGE=3, load followed by a dependent instruction -> stall for 2 cycles, then fwd_sel=3. With FWD_PERF_CNT_EN defined -> perf_stall_cnt=2.

Source files
------------

// File: rtl/fwd_hazard_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_tracker
//  Purpose  : RV32I forwarding-select and load-use stall unit built around a
//             self-maintained shift-register scoreboard of in-flight writes.
//             Optional performance counters: define FWD_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_tracker #(
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_DEPTH  = 2,
    parameter  int ADDR_W     = 5,
    parameter  int LOAD_STAGE = 2,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      advance,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic                      busy
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fwd_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam logic [SEL_W-1:0] c_load_stage = SEL_W'(LOAD_STAGE);

    // Scoreboard: index 1 is the youngest in-flight producer.
    logic [FWD_DEPTH:1]  r_v;
    logic [FWD_DEPTH:1]  r_ld;
    logic [ADDR_W-1:0]   r_rd [1:FWD_DEPTH];

    logic [NUM_SRC-1:0]  w_hazard;
    logic                w_new_valid;

    assign w_new_valid = id_valid & id_regwrite & (id_rd != '0) & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (advance) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                r_v[k]  <= r_v[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            r_v[1]  <= w_new_valid;
            r_ld[1] <= id_is_load;
            r_rd[1] <= id_rd;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic [ADDR_W-1:0] w_src;
            logic              w_hit;
            logic              w_hit_ld;
            logic [SEL_W-1:0]  w_idx;

            assign w_src = src_addr[i*ADDR_W +: ADDR_W];

            // Scan oldest to youngest so the youngest match overwrites the rest.
            always_comb begin
                w_hit    = 1'b0;
                w_hit_ld = 1'b0;
                w_idx    = '0;
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (r_v[k] && (r_rd[k] == w_src)) begin
                        w_hit    = 1'b1;
                        w_hit_ld = r_ld[k];
                        w_idx    = SEL_W'(k);
                    end
                end
                if (w_src == '0) begin
                    w_hit = 1'b0;
                end
            end

            assign w_hazard[i] = w_hit & w_hit_ld & (w_idx < c_load_stage);
            assign fwd_sel[i*SEL_W +: SEL_W] = (w_hit && !w_hazard[i]) ? w_idx : '0;
        end
    endgenerate

    assign stall = |w_hazard;
    assign busy  = |r_v;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_perf_fwd_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fwd_cnt   <= '0;
            r_perf_stall_cnt <= '0;
        end else if (advance) begin
            if (stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end else if (|fwd_sel) begin
                r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
            end
        end
    end

    assign perf_fwd_cnt   = r_perf_fwd_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_tracker.sv
`default_nettype none
// Bench: two instances (default params, and FWD_DEPTH=4/LOAD_STAGE=3) checked
// against a list-of-entries scoreboard model plus directed expectations.
module tb_fwd_hazard_tracker;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       adv   [2];
    logic       fl    [2];
    logic       vld   [2];
    logic       rw    [2];
    logic       ld    [2];
    logic [4:0] rd    [2];
    logic [9:0] src   [2];

    logic [3:0] fwd_a;
    logic [5:0] fwd_b;
    logic       stall_a, stall_b, busy_a, busy_b;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

    ent_t        mdl [2][1:6];
    int          dep [2] = '{2, 4};
    int          lst [2] = '{2, 3};
    int          sw  [2] = '{2, 3};
    int unsigned m_pf [2];
    int unsigned m_ps [2];

    int checks   = 0;
    int failures = 0;

    fwd_hazard_tracker dut_a (
        .clk(clk), .rst_n(rst_n), .advance(adv[0]), .flush(fl[0]),
        .id_valid(vld[0]), .id_regwrite(rw[0]), .id_is_load(ld[0]), .id_rd(rd[0]),
        .src_addr(src[0]), .fwd_sel(fwd_a), .stall(stall_a), .busy(busy_a)
`ifdef FWD_PERF_CNT_EN
        , .perf_fwd_cnt(pf_a), .perf_stall_cnt(ps_a)
`endif
    );

    fwd_hazard_tracker #(.FWD_DEPTH(4), .LOAD_STAGE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .advance(adv[1]), .flush(fl[1]),
        .id_valid(vld[1]), .id_regwrite(rw[1]), .id_is_load(ld[1]), .id_rd(rd[1]),
        .src_addr(src[1]), .fwd_sel(fwd_b), .stall(stall_b), .busy(busy_b)
`ifdef FWD_PERF_CNT_EN
        , .perf_fwd_cnt(pf_b), .perf_stall_cnt(ps_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Youngest valid producer of s decides; a too-young load means hazard.
    function automatic void look(input int u, input logic [4:0] s, output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (s == 5'd0) return;
        for (int k = 1; k <= dep[u]; k++) begin
            if (mdl[u][k].v && mdl[u][k].rd == s) begin
                if (mdl[u][k].ld && k < lst[u]) hz = 1'b1;
                else sel = k;
                return;
            end
        end
    endfunction

    function automatic void expect_out(input int u, output logic [5:0] sel, output logic st, output logic bz);
        int s;
        bit h;
        sel = '0;
        st  = 1'b0;
        bz  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            look(u, src[u][i*5 +: 5], s, h);
            sel = sel | (6'(s) << (i * sw[u]));
            st  = st | h;
        end
        for (int k = 1; k <= dep[u]; k++) bz = bz | mdl[u][k].v;
    endfunction

    task automatic clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int k = 1; k <= 6; k++) mdl[u][k] = '0;
            m_pf[u] = 0;
            m_ps[u] = 0;
        end
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            adv[u] = 1'b1; fl[u] = 1'b0; vld[u] = 1'b0; rw[u] = 1'b0;
            ld[u] = 1'b0; rd[u] = 5'd0; src[u] = 10'd0;
        end
    endtask

    task automatic issue(input int u, input logic [4:0] r, input logic is_ld, input logic f);
        vld[u] = 1'b1; rw[u] = 1'b1; rd[u] = r; ld[u] = is_ld; fl[u] = f;
    endtask

    // One clock: advance the model exactly as the pipeline should, no checking.
    task automatic tick();
        logic [5:0] s;
        logic       st [2];
        logic       anyf [2];
        logic       bz;
        for (int u = 0; u < 2; u++) begin
            expect_out(u, s, st[u], bz);
            anyf[u] = |s;
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (rst_n && adv[u]) begin
                if (st[u]) m_ps[u]++;
                else if (anyf[u]) m_pf[u]++;
                for (int k = dep[u]; k >= 2; k--) mdl[u][k] = mdl[u][k-1];
                mdl[u][1].v  = vld[u] & rw[u] & (rd[u] != 5'd0) & ~st[u] & ~fl[u];
                mdl[u][1].rd = rd[u];
                mdl[u][1].ld = ld[u];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        src[0] = 10'h0A5;
        src[1] = 10'h0A5;
        clear_model();
        #1;
        checks++;
        if (fwd_a !== 4'd0 || stall_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: fwd=%0h stall=%0b busy=%0b, want 0/0/0", fwd_a, stall_a, busy_a);
        end
        checks++;
        if (fwd_b !== 6'd0 || stall_b !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: fwd=%0h stall=%0b busy=%0b, want 0/0/0", fwd_b, stall_b, busy_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(0, 5'd5, 1'b0, 1'b0);
        tick();
        idle_inputs();
        src[0][4:0] = 5'd5;
        #1;
        checks++;
        if (fwd_a[1:0] !== 2'd1 || stall_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ex: sel=%0d stall=%0b, want 1/0", fwd_a[1:0], stall_a);
        end
        tick();
        checks++;
        if (fwd_a[1:0] !== 2'd2 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ma: sel=%0d busy=%0b, want 2/1", fwd_a[1:0], busy_a);
        end
        tick();
        checks++;
        if (fwd_a[1:0] !== 2'd0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_expired: sel=%0d busy=%0b, want 0/0", fwd_a[1:0], busy_a);
        end
        // Youngest of two writes to x7 must win.
        issue(0, 5'd7, 1'b0, 1'b0);
        tick();
        tick();
        idle_inputs();
        src[0][9:5] = 5'd7;
        #1;
        checks++;
        if (fwd_a[3:2] !== 2'd1) begin
            failures++;
            $display("FAIL youngest_wins: sel1=%0d, want 1", fwd_a[3:2]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(0, 5'd3, 1'b1, 1'b0);
        tick();
        issue(0, 5'd11, 1'b0, 1'b0);
        src[0][4:0] = 5'd3;
        #1;
        checks++;
        if (stall_a !== 1'b1 || fwd_a[1:0] !== 2'd0) begin
            failures++;
            $display("FAIL load_use_stall: stall=%0b sel=%0d, want 1/0", stall_a, fwd_a[1:0]);
        end
        tick();
        checks++;
        if (stall_a !== 1'b0 || fwd_a[1:0] !== 2'd2) begin
            failures++;
            $display("FAIL load_use_after: stall=%0b sel=%0d, want 0/2", stall_a, fwd_a[1:0]);
        end
        // The dependent instruction was bubbled, so x11 must not be in flight.
        src[0][9:5] = 5'd11;
        #1;
        checks++;
        if (fwd_a[3:2] !== 2'd0) begin
            failures++;
            $display("FAIL load_use_bubble: sel1=%0d, want 0", fwd_a[3:2]);
        end
    endtask

    task automatic test_x0_flush();
        do_reset();
        issue(0, 5'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (fwd_a !== 4'd0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL x0_write: fwd=%0h busy=%0b, want 0/0", fwd_a, busy_a);
        end
        issue(0, 5'd9, 1'b0, 1'b1);
        tick();
        idle_inputs();
        src[0] = {5'd9, 5'd9};
        #1;
        checks++;
        if (fwd_a !== 4'd0) begin
            failures++;
            $display("FAIL flush_squash: fwd=%0h, want 0", fwd_a);
        end
    endtask

    task automatic test_freeze_reset();
        do_reset();
        issue(0, 5'd4, 1'b0, 1'b0);
        tick();
        idle_inputs();
        src[0][4:0] = 5'd4;
        for (int c = 0; c < 3; c++) begin
            adv[0] = 1'b0;
            issue(0, 5'd6, 1'b0, c[0]);
            tick();
            checks++;
            if (fwd_a[1:0] !== 2'd1 || busy_a !== 1'b1) begin
                failures++;
                $display("FAIL freeze_hold%0d: sel=%0d busy=%0b, want 1/1", c, fwd_a[1:0], busy_a);
            end
        end
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (fwd_a !== 4'd0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: fwd=%0h busy=%0b, want 0/0", fwd_a, busy_a);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_param();
        do_reset();
        issue(1, 5'd8, 1'b1, 1'b0);
        tick();
        issue(1, 5'd12, 1'b0, 1'b0);
        src[1][4:0] = 5'd8;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (stall_b !== 1'b1 || fwd_b[2:0] !== 3'd0) begin
                failures++;
                $display("FAIL param_stall%0d: stall=%0b sel=%0d, want 1/0", c, stall_b, fwd_b[2:0]);
            end
            tick();
        end
        checks++;
        if (stall_b !== 1'b0 || fwd_b[2:0] !== 3'd3) begin
            failures++;
            $display("FAIL param_fwd: stall=%0b sel=%0d, want 0/3", stall_b, fwd_b[2:0]);
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (ps_b !== 32'd2) begin
            failures++;
            $display("FAIL param_perf_stall: got %0d want 2", ps_b);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] es;
        logic       est, ebz;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int u = 0; u < 2; u++) begin
                adv[u] = ($urandom_range(0, 9) < 8);
                fl[u]  = ($urandom_range(0, 9) == 0);
                vld[u] = ($urandom_range(0, 9) < 8);
                rw[u]  = ($urandom_range(0, 9) < 8);
                ld[u]  = ($urandom_range(0, 9) < 3);
                rd[u]  = 5'($urandom_range(0, 7));
                src[u] = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            end
            #1;
            expect_out(0, es, est, ebz);
            checks++;
            if (fwd_a !== es[3:0] || stall_a !== est || busy_a !== ebz) begin
                failures++;
                $display("FAIL rand_a@%0d: fwd=%0h stall=%0b busy=%0b, want %0h/%0b/%0b",
                         n, fwd_a, stall_a, busy_a, es[3:0], est, ebz);
            end
            expect_out(1, es, est, ebz);
            checks++;
            if (fwd_b !== es || stall_b !== est || busy_b !== ebz) begin
                failures++;
                $display("FAIL rand_b@%0d: fwd=%0h stall=%0b busy=%0b, want %0h/%0b/%0b",
                         n, fwd_b, stall_b, busy_b, es, est, ebz);
            end
            tick();
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (pf_a !== m_pf[0] || ps_a !== m_ps[0] || pf_b !== m_pf[1] || ps_b !== m_ps[1]) begin
            failures++;
            $display("FAIL rand_perf: a=%0d/%0d b=%0d/%0d, want %0d/%0d %0d/%0d",
                     pf_a, ps_a, pf_b, ps_b, m_pf[0], m_ps[0], m_pf[1], m_ps[1]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_flush();
        test_freeze_reset();
        test_param();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
